sa9_rr_scheduler: RTL and testbench

Round-robin scheduler that shares one downstream resource (bus/port) among the five sibling leaf instances of a `rootModule500_*_sa8_*` level, indices sa9_0..sa9_4. Each leaf raises a request. The scheduler issues one exclusive grant at a time and holds it until the owner signals done. An optional hold-timeout revokes grants from owners that never release. The block is instantiated once per sa8 parent, alongside the five leaves.

---
 rtl/sa9_rr_scheduler.sv | 150 +++++++++++++++
 tb/tb_sa9_rr_scheduler.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sa9_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : sa9_rr_scheduler
// Brief    : Round-robin scheduler granting one shared resource to NUM_REQ
//            leaf requesters; a grant is held until the owner signals done.
//            Optional hold timeout compiled in with SA9_HOLD_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sa9_rr_scheduler #(
    parameter int NUM_REQ  = 5,
    parameter int HOLD_MAX = 16,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_REQ-1:0]  req,
    input  logic [NUM_REQ-1:0]  done,
    output logic [NUM_REQ-1:0]  gnt,
    output logic [ID_W-1:0]     gnt_id,
    output logic                busy,
    output logic                timeout_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    if (NUM_REQ < 2 || NUM_REQ > 16 || HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_params
        $error("sa9_rr_scheduler: parameter out of range");
    end

    state_t               r_state;
    state_t               w_state_nxt;
    logic [ID_W-1:0]      r_ptr;
    logic [ID_W-1:0]      w_ptr_nxt;
    logic [NUM_REQ-1:0]   r_gnt;
    logic [NUM_REQ-1:0]   w_gnt_nxt;
    logic [ID_W-1:0]      r_gnt_id;
    logic [ID_W-1:0]      w_gnt_id_nxt;
    logic                 r_busy;
    logic                 r_timeout_pulse;
    logic                 w_timeout_pulse_nxt;

    logic                 w_win_valid;
    logic [ID_W-1:0]      w_win_idx;
    logic [ID_W-1:0]      w_ptr_adv;
    logic                 w_owner_done;
    logic                 w_hold_expired;

    function automatic logic [ID_W-1:0] f_wrap(input logic [ID_W-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NUM_REQ) s = s - NUM_REQ;
        return ID_W'(s);
    endfunction

    // Scan from the highest offset down so the nearest requester at or above
    // ptr is the last (and therefore winning) assignment.
    always_comb begin
        w_win_valid = 1'b0;
        w_win_idx   = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (req[f_wrap(r_ptr, i)]) begin
                w_win_valid = 1'b1;
                w_win_idx   = f_wrap(r_ptr, i);
            end
        end
    end

    assign w_ptr_adv    = (r_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : r_gnt_id + ID_W'(1);
    assign w_owner_done = done[r_gnt_id];

`ifdef SA9_HOLD_TIMEOUT_EN
    localparam logic [7:0] c_hold_last = 8'(HOLD_MAX - 1);
    logic [7:0] r_hold_cnt;

    // Zero outside GRANT, so the count restarts on every grant entry.
    always_ff @(posedge clk) begin
        if (rst || r_state != ST_GRANT) begin
            r_hold_cnt <= 8'd0;
        end else begin
            r_hold_cnt <= r_hold_cnt + 8'd1;
        end
    end

    assign w_hold_expired = (r_state == ST_GRANT) && (r_hold_cnt == c_hold_last);
`else
    assign w_hold_expired = 1'b0;
`endif

    always_comb begin
        w_state_nxt         = r_state;
        w_ptr_nxt           = r_ptr;
        w_gnt_nxt           = r_gnt;
        w_gnt_id_nxt        = r_gnt_id;
        w_timeout_pulse_nxt = 1'b0;
        case (r_state)
            ST_IDLE, ST_GAP: begin
                w_gnt_nxt = '0;
                if (w_win_valid) begin
                    w_state_nxt  = ST_GRANT;
                    w_gnt_nxt    = NUM_REQ'(1) << w_win_idx;
                    w_gnt_id_nxt = w_win_idx;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_GRANT: begin
                // done takes priority over a coinciding timeout
                if (w_owner_done || w_hold_expired) begin
                    w_state_nxt         = ST_GAP;
                    w_gnt_nxt           = '0;
                    w_ptr_nxt           = w_ptr_adv;
                    w_timeout_pulse_nxt = !w_owner_done;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state         <= ST_IDLE;
            r_ptr           <= '0;
            r_gnt           <= '0;
            r_gnt_id        <= '0;
            r_busy          <= 1'b0;
            r_timeout_pulse <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_ptr           <= w_ptr_nxt;
            r_gnt           <= w_gnt_nxt;
            r_gnt_id        <= w_gnt_id_nxt;
            r_busy          <= |w_gnt_nxt;
            r_timeout_pulse <= w_timeout_pulse_nxt;
        end
    end

    assign gnt           = r_gnt;
    assign gnt_id        = r_gnt_id;
    assign busy          = r_busy;
    assign timeout_pulse = r_timeout_pulse;

endmodule
`default_nettype wire

// File: tb/tb_sa9_rr_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_sa9_rr_scheduler
// Brief    : Self-checking bench for sa9_rr_scheduler: directed scenarios with
//            literal expectations plus randomized traffic against a model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sa9_rr_scheduler;

    localparam int N    = 5;
    localparam int HOLD = 16;
    localparam int IDW  = $clog2(N);
`ifdef SA9_HOLD_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic           clk;
    logic           rst;
    logic [N-1:0]   req;
    logic [N-1:0]   done;
    logic [N-1:0]   gnt;
    logic [IDW-1:0] gnt_id;
    logic           busy;
    logic           timeout_pulse;

    int n_checks = 0;
    int n_pass   = 0;

    sa9_rr_scheduler #(
        .NUM_REQ  (N),
        .HOLD_MAX (HOLD),
        .ID_W     (IDW)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req           (req),
        .done          (done),
        .gnt           (gnt),
        .gnt_id        (gnt_id),
        .busy          (busy),
        .timeout_pulse (timeout_pulse)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who owns the resource (-1 = nobody), last owner, pointer,
    // number of completed grant cycles, and whether this cycle is a revocation gap.
    int m_owner = -1;
    int m_last  = 0;
    int m_ptr   = 0;
    int m_held  = 0;
    bit m_tp    = 1'b0;

    always @(posedge clk) begin
        m_tp = 1'b0;
        if (rst) begin
            m_owner = -1;
            m_last  = 0;
            m_ptr   = 0;
            m_held  = 0;
        end else if (m_owner >= 0) begin
            m_held++;
            if (done[m_owner] || (TO_EN && m_held == HOLD)) begin
                m_tp    = !done[m_owner];
                m_ptr   = (m_owner + 1) % N;
                m_owner = -1;
            end
        end else begin
            for (int k = 0; k < N; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % N]) begin
                    m_owner = (m_ptr + k) % N;
                    m_last  = m_owner;
                    m_held  = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? N'(1) << m_owner : '0;
        check("model_gnt",    32'(gnt),           32'(exp_gnt));
        check("model_gnt_id", 32'(gnt_id),        32'(m_last));
        check("model_busy",   32'(busy),          32'(m_owner >= 0));
        check("model_tpulse", 32'(timeout_pulse), 32'(m_tp));
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        done = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [N-1:0] rot_exp [11];
        rst  = 1'b1;
        req  = '0;
        done = '0;

        // Reset held with all requesting
        req = 5'b11111;
        repeat (3) begin
            tick();
            check("rst_gnt",    32'(gnt),           32'h0);
            check("rst_busy",   32'(busy),          32'h0);
            check("rst_gnt_id", 32'(gnt_id),        32'h0);
            check("rst_tpulse", 32'(timeout_pulse), 32'h0);
        end
        rst = 1'b0;
        tick();
        check("rst_first_gnt", 32'(gnt), 32'h01);
        done = 5'b00001;
        tick();
        check("rst_gap", 32'(gnt), 32'h00);
        done = '0;
        tick();
        check("rst_second_gnt", 32'(gnt), 32'h02);
        check("rst_second_id",  32'(gnt_id), 32'd1);

        // Single requester, four-cycle grant
        do_reset();
        req = 5'b00100;
        tick();
        for (int c = 1; c <= 4; c++) begin
            check("single_hold", 32'(gnt), 32'h04);
            if (c == 4) done = 5'b00100;
            tick();
        end
        done = '0;
        check("single_gap", 32'(gnt), 32'h00);
        tick();
        check("single_regrant", 32'(gnt), 32'h04);

        // Rotation with done on each owner's first cycle
        do_reset();
        rot_exp = '{5'h01, 5'h00, 5'h02, 5'h00, 5'h04, 5'h00, 5'h08, 5'h00, 5'h10, 5'h00, 5'h01};
        req = 5'b11111;
        for (int c = 0; c < 11; c++) begin
            tick();
            check("rotation", 32'(gnt), 32'(rot_exp[c]));
            done = gnt;
        end
        done = '0;

        // Foreign done bits are ignored
        do_reset();
        req = 5'b00010;
        tick();
        check("foreign_first", 32'(gnt), 32'h02);
        done = 5'b01101;
        repeat (5) begin
            tick();
            check("foreign_hold", 32'(gnt), 32'h02);
            check("foreign_busy", 32'(busy), 32'h1);
        end
        done = '0;

`ifdef SA9_HOLD_TIMEOUT_EN
        // Owner 3 never releases
        do_reset();
        req = 5'b11000;
        tick();
        for (int c = 1; c <= HOLD; c++) begin
            check("to_hold", 32'(gnt), 32'h08);
            tick();
        end
        check("to_gap_gnt",   32'(gnt),           32'h00);
        check("to_gap_pulse", 32'(timeout_pulse), 32'h1);
        tick();
        check("to_next_gnt",   32'(gnt),           32'h10);
        check("to_next_pulse", 32'(timeout_pulse), 32'h0);

        // done coinciding with the limit wins
        do_reset();
        req = 5'b11000;
        tick();
        for (int c = 1; c <= HOLD; c++) begin
            check("to_done_hold", 32'(gnt), 32'h08);
            if (c == HOLD) done = 5'b01000;
            tick();
        end
        done = '0;
        check("to_done_gap",   32'(gnt),           32'h00);
        check("to_done_pulse", 32'(timeout_pulse), 32'h0);
`endif

        // Reset during the second cycle of a grant to requester 4
        do_reset();
        req = 5'b10000;
        tick();
        check("midrst_first", 32'(gnt), 32'h10);
        tick();
        check("midrst_second", 32'(gnt), 32'h10);
        rst = 1'b1;
        req = 5'b11111;
        tick();
        check("midrst_drop",   32'(gnt),           32'h00);
        check("midrst_tpulse", 32'(timeout_pulse), 32'h0);
        rst = 1'b0;
        tick();
        check("midrst_regrant", 32'(gnt), 32'h01);

        // Randomized traffic, checked every cycle by the model comparator
        for (int c = 0; c < 3000; c++) begin
            req  = N'($urandom);
            done = N'($urandom) & N'($urandom);
            rst  = ($urandom_range(0, 249) == 0);
            tick();
        end
        rst  = 1'b0;
        req  = '0;
        done = '0;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
